ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Pipeline hazard controller for the five-stage core. It sequences the execute stage by tracking in-flight destination registers in EX, MEM and WB, generating the registered forwarding selects for the execute operand muxes, inserting load-use bubbles, flushing on taken branches/jumps, and freezing the pipeline while data memory is busy. It sits beside the ID/EX register and drives the fetch, IF/ID and ID/EX enables and flushes.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush performance counters
- WB_SEL_LOAD, 2'b01, wb_sel encoding that marks a load (memory read data)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1, i_id_rs2  in  5  ID source register indices
- i_id_rs1_used, i_id_rs2_used  in  1  source is actually read
- i_id_rd  in  5  ID destination index
- i_id_wb_en  in  1  ID instruction writes rd
- i_id_wb_sel  in  2  ID writeback source select
- i_ex_do_branch  in  1  EX resolves a taken branch or jump
- i_mem_busy  in  1  data memory not ready; whole pipeline freezes
- o_pc_en  out  1  PC update enable
- o_ifid_en  out  1  IF/ID register enable
- o_ifid_flush  out  1  load a bubble into IF/ID
- o_idex_flush  out  1  load a bubble into ID/EX
- o_r1_fw_sel, o_r2_fw_sel  out  2  operand select for the instruction in EX: 0 register file, 1 MEM forward, 2 WB forward
- o_stall_cnt  out  CNT_W  load-use bubbles inserted
- o_flush_cnt  out  CNT_W  taken-branch flushes

## Operation
- Internal shadow slots EX, MEM, WB, each {valid, rd, wb_en, is_load}; is_load = (wb_sel == WB_SEL_LOAD). A slot is a hazard source only if valid & wb_en & rd != 0.
- Register file is write-before-read; no forwarding is needed for a source matching the WB slot at ID time.
- Priority per cycle: freeze > branch flush > load-use stall > normal advance.
- Freeze (i_mem_busy=1): o_pc_en=0, o_ifid_en=0, both flushes 0; slots, fw selects and counters hold.
- Branch (i_ex_do_branch=1, not frozen): o_pc_en=1, o_ifid_flush=1, o_idex_flush=1; slots shift (EX->MEM->WB), EX slot gets invalid; fw selects load 0; o_flush_cnt += 1.
- Load-use (EX slot is_load and matches a used ID source, i_id_valid=1): o_pc_en=0, o_ifid_en=0, o_idex_flush=1; slots shift, EX slot invalid; fw selects load 0; o_stall_cnt += 1. Exactly one bubble per load-use pair.
- Normal advance: o_pc_en=1, o_ifid_en=1, flushes 0; slots shift, EX slot loads ID info (valid = i_id_valid). Per used source: match current EX slot -> sel 1; else match current MEM slot -> sel 2; else 0. Unused sources get 0. EX match has priority over MEM.
- Counters wrap modulo 2^CNT_W.

## Timing
- fw selects registered; value computed at the edge where ID advances into EX and valid for the whole EX residence of that instruction.
- Enables and flushes are combinational from current slots and inputs in the same cycle.
- Load-use latency: one stall cycle; consumer then enters EX with sel 2 (load now in WB).
- Branch in EX on a cycle where a load-use condition also holds: only the flush happens; o_stall_cnt unchanged.
- Branch asserted during freeze: acted on the first cycle i_mem_busy is 0 (EX held stable by freeze).
- Reset (any time, async): all slots invalid, fw selects 0, counters 0; with slots invalid and i_mem_busy=0, outputs are o_pc_en=1, o_ifid_en=1, flushes 0. Mid-stall reset abandons the bubble.

## Test plan
- add x5 in EX, ID reads rs1=x5 (used) -> next cycle o_r1_fw_sel=1, o_r2_fw_sel=0; one cycle later a consumer of x5 in ID -> sel 2.
- lw x7 in EX, ID uses rs2=x7 -> o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for 1 cycle, o_stall_cnt=1; next advance gives o_r2_fw_sel=2.
- Producer rd=x0 followed by consumer of x0 -> no stall, sel 0.
- i_ex_do_branch=1 together with load-use match -> both flushes 1, o_pc_en=1, o_flush_cnt=1, o_stall_cnt=0, fw selects 0 next cycle.
- i_mem_busy high 3 cycles during a pending forward -> enables 0 for 3 cycles, selects and counters unchanged, then advance resumes with correct sel.
- rst pulsed while in load-use stall -> immediately selects 0, counters 0, o_pc_en=1; CNT_W=4 with 16 flushes -> o_flush_cnt wraps to 0.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use bubbles,
// branch flushes and memory-busy freeze for the five-stage pipeline.
module ex_hazard_ctrl #(
  parameter int         CNT_W       = 32,
  parameter logic [1:0] WB_SEL_LOAD = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_wb_en,
  input  logic [1:0]       i_id_wb_sel,
  input  logic             i_ex_do_branch,
  input  logic             i_mem_busy,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [1:0]       o_r1_fw_sel,
  output logic [1:0]       o_r2_fw_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // A used source operand hits a slot that will write a nonzero register.
  function automatic logic src_hit(input logic       src_ok,
                                   input logic [4:0] slot_rd,
                                   input logic       used,
                                   input logic [4:0] rs);
    return src_ok & used & (slot_rd == rs);
  endfunction

  // EX slot carries load type; for MEM only its hazard-source status matters.
  // Nothing is tracked past MEM because the register file is write-before-read.
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_wb_en_q, ex_wb_en_d;
  logic       ex_load_q, ex_load_d;
  logic       mem_src_q, mem_src_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic [1:0] r1_sel_q, r1_sel_d;
  logic [1:0] r2_sel_q, r2_sel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_src_s;
  logic load_use_s;
  logic branch_s;
  logic stall_s;

  assign ex_src_s   = ex_valid_q & ex_wb_en_q & (ex_rd_q != 5'd0);
  assign load_use_s = i_id_valid & ex_load_q &
                      (src_hit(ex_src_s, ex_rd_q, i_id_rs1_used, i_id_rs1) |
                       src_hit(ex_src_s, ex_rd_q, i_id_rs2_used, i_id_rs2));
  assign branch_s   = ~i_mem_busy & i_ex_do_branch;
  assign stall_s    = ~i_mem_busy & ~i_ex_do_branch & load_use_s;

  // Pipeline enables and flushes, prioritised freeze > branch > load-use.
  always_comb begin
    o_pc_en      = 1'b1;
    o_ifid_en    = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    if (i_mem_busy) begin
      o_pc_en   = 1'b0;
      o_ifid_en = 1'b0;
    end else if (i_ex_do_branch) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (load_use_s) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end else begin
      o_pc_en = 1'b1;
    end
  end

  // Next slot contents, forwarding selects and counters.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_wb_en_d  = ex_wb_en_q;
    ex_load_d   = ex_load_q;
    mem_src_d   = mem_src_q;
    mem_rd_d    = mem_rd_q;
    r1_sel_d    = r1_sel_q;
    r2_sel_d    = r2_sel_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!i_mem_busy) begin
      mem_src_d = ex_src_s;
      mem_rd_d  = ex_rd_q;
      if (branch_s || stall_s) begin
        ex_valid_d = 1'b0;
        ex_rd_d    = 5'd0;
        ex_wb_en_d = 1'b0;
        ex_load_d  = 1'b0;
        r1_sel_d   = SEL_RF;
        r2_sel_d   = SEL_RF;
        if (branch_s) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end else begin
        ex_valid_d = i_id_valid;
        ex_rd_d    = i_id_rd;
        ex_wb_en_d = i_id_wb_en;
        ex_load_d  = (i_id_wb_sel == WB_SEL_LOAD);
        if (src_hit(ex_src_s, ex_rd_q, i_id_rs1_used, i_id_rs1)) begin
          r1_sel_d = SEL_MEM;
        end else if (src_hit(mem_src_q, mem_rd_q, i_id_rs1_used, i_id_rs1)) begin
          r1_sel_d = SEL_WB;
        end else begin
          r1_sel_d = SEL_RF;
        end
        if (src_hit(ex_src_s, ex_rd_q, i_id_rs2_used, i_id_rs2)) begin
          r2_sel_d = SEL_MEM;
        end else if (src_hit(mem_src_q, mem_rd_q, i_id_rs2_used, i_id_rs2)) begin
          r2_sel_d = SEL_WB;
        end else begin
          r2_sel_d = SEL_RF;
        end
      end
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // State registers; a reset abandons any bubble in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_wb_en_q  <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_src_q   <= 1'b0;
      mem_rd_q    <= 5'd0;
      r1_sel_q    <= SEL_RF;
      r2_sel_q    <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_wb_en_q  <= ex_wb_en_d;
      ex_load_q   <= ex_load_d;
      mem_src_q   <= mem_src_d;
      mem_rd_q    <= mem_rd_d;
      r1_sel_q    <= r1_sel_d;
      r2_sel_q    <= r2_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_r1_fw_sel = r1_sel_q;
  assign o_r2_fw_sel = r2_sel_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with an in-bench instruction-level model.
module tb_ex_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, u1 = 1'b0, u2 = 1'b0, wb = 1'b0, br = 1'b0, busy = 1'b0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [1:0] wbsel = 2'd0;
  logic pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0] r1_sel, r2_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  ex_hazard_ctrl #(.CNT_W(CW), .WB_SEL_LOAD(2'b01)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(rd),
    .i_id_wb_en(wb), .i_id_wb_sel(wbsel),
    .i_ex_do_branch(br), .i_mem_busy(busy),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_flush(idex_flush), .o_r1_fw_sel(r1_sel), .o_r2_fw_sel(r2_sel),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // In-flight instructions: index 0 is the one in EX, index 1 the one in MEM.
  typedef struct { bit v; bit [4:0] rd; bit wb; bit ld; } instr_t;
  instr_t pipe[2];
  int m_r1, m_r2, m_stall, m_flush;

  function automatic bit produces(instr_t r, bit [4:0] x);
    return r.v && r.wb && r.rd != 5'd0 && r.rd == x;
  endfunction

  function automatic bit m_load_use();
    return id_valid && pipe[0].ld &&
           ((u1 && produces(pipe[0], rs1)) || (u2 && produces(pipe[0], rs2)));
  endfunction

  function automatic int fwd(bit used, bit [4:0] x);
    if (!used) return 0;
    if (produces(pipe[0], x)) return 1;
    if (produces(pipe[1], x)) return 2;
    return 0;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe[0] = '{0, 5'd0, 0, 0};
    pipe[1] = '{0, 5'd0, 0, 0};
    m_r1 = 0; m_r2 = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_model();
    int e_pc, e_ifid, e_iff, e_idf;
    if (busy) begin
      e_pc = 0; e_ifid = 0; e_iff = 0; e_idf = 0;
    end else if (br) begin
      e_pc = 1; e_ifid = 1; e_iff = 1; e_idf = 1;
    end else if (m_load_use()) begin
      e_pc = 0; e_ifid = 0; e_iff = 0; e_idf = 1;
    end else begin
      e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0;
    end
    cmp("pc_en", int'(pc_en), e_pc);
    cmp("ifid_en", int'(ifid_en), e_ifid);
    cmp("ifid_flush", int'(ifid_flush), e_iff);
    cmp("idex_flush", int'(idex_flush), e_idf);
    cmp("r1_sel", int'(r1_sel), m_r1);
    cmp("r2_sel", int'(r2_sel), m_r2);
    cmp("stall_cnt", int'(stall_cnt), m_stall);
    cmp("flush_cnt", int'(flush_cnt), m_flush);
  endtask

  task automatic model_update();
    bit lu;
    if (busy) return;
    lu = m_load_use();
    if (br || lu) begin
      pipe[1] = pipe[0];
      pipe[0] = '{0, 5'd0, 0, 0};
      m_r1 = 0; m_r2 = 0;
      if (br) m_flush = (m_flush + 1) % 16;
      else    m_stall = (m_stall + 1) % 16;
    end else begin
      m_r1 = fwd(u1, rs1);
      m_r2 = fwd(u2, rs2);
      pipe[1] = pipe[0];
      pipe[0] = '{id_valid, rd, wb, wbsel == 2'b01};
    end
  endtask

  task automatic drive(input bit v, input bit [4:0] a, input bit ua, input bit [4:0] b,
                       input bit ub, input bit [4:0] d, input bit w, input bit [1:0] s,
                       input bit br_i, input bit bz);
    id_valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; wb = w; wbsel = s;
    br = br_i; busy = bz;
  endtask

  task automatic step(input bit v, input bit [4:0] a, input bit ua, input bit [4:0] b,
                      input bit ub, input bit [4:0] d, input bit w, input bit [1:0] s,
                      input bit br_i, input bit bz);
    drive(v, a, ua, b, ub, d, w, s, br_i, bz);
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    // Reset state, hand-computed
    cmp("rst_pc_en", int'(pc_en), 1);
    cmp("rst_ifid_en", int'(ifid_en), 1);
    cmp("rst_r1", int'(r1_sel), 0);
    cmp("rst_stall", int'(stall_cnt), 0);

    // add x5, then two consumers of x5
    step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'b00, 0, 0);
    step(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 2'b00, 0, 0);
    cmp("lit_ex_fwd_r1", int'(r1_sel), 1);
    cmp("lit_ex_fwd_r2", int'(r2_sel), 0);
    step(1, 5'd4, 0, 5'd5, 1, 5'd8, 1, 2'b00, 0, 0);
    cmp("lit_mem_fwd_r2", int'(r2_sel), 2);

    // lw x7, consumer uses rs2=x7: one bubble then WB forward
    step(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'b01, 0, 0);
    step(1, 5'd1, 1, 5'd7, 1, 5'd9, 1, 2'b00, 0, 0);
    cmp("lit_stall_cnt", int'(stall_cnt), 1);
    step(1, 5'd1, 1, 5'd7, 1, 5'd9, 1, 2'b00, 0, 0);
    cmp("lit_lu_r2", int'(r2_sel), 2);

    // Producer targeting x0 never forwards or stalls
    step(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'b01, 0, 0);
    step(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 2'b00, 0, 0);
    cmp("lit_x0_r1", int'(r1_sel), 0);
    cmp("lit_x0_stall", int'(stall_cnt), 1);

    // Branch coinciding with a load-use match: flush only
    step(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'b01, 0, 0);
    step(1, 5'd9, 1, 5'd9, 1, 5'd12, 1, 2'b00, 1, 0);
    cmp("lit_br_flush", int'(flush_cnt), 1);
    cmp("lit_br_stall", int'(stall_cnt), 1);
    cmp("lit_br_r1", int'(r1_sel), 0);

    // Three-cycle freeze with a forward pending, then advance
    step(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5'd10, 1, 5'd0, 0, 5'd13, 1, 2'b00, 0, 1);
    cmp("lit_frz_r1", int'(r1_sel), 0);
    cmp("lit_frz_flush", int'(flush_cnt), 1);
    step(1, 5'd10, 1, 5'd0, 0, 5'd13, 1, 2'b00, 0, 0);
    cmp("lit_frz_resume_r1", int'(r1_sel), 1);

    // Branch held through a freeze is taken once busy drops
    step(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 2'b00, 1, 1);
    step(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 2'b00, 1, 0);
    cmp("lit_frz_br", int'(flush_cnt), 2);

    // Reset in the middle of a load-use stall
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 2'b01, 0, 0);
    drive(1, 5'd3, 1, 5'd0, 0, 5'd15, 1, 2'b00, 0, 0);
    @(negedge clk);
    check_model();
    cmp("lit_pre_rst_pc", int'(pc_en), 0);
    #1 rst = 1'b1;
    #1 model_reset();
    cmp("lit_mid_rst_pc", int'(pc_en), 1);
    cmp("lit_mid_rst_r1", int'(r1_sel), 0);
    cmp("lit_mid_rst_stall", int'(stall_cnt), 0);
    cmp("lit_mid_rst_flush", int'(flush_cnt), 0);
    #1 rst = 1'b0;
    check_model();
    @(posedge clk);
    model_update();
    #1;

    // Sixteen flushes wrap a 4-bit counter
    for (int i = 0; i < 16; i++) step(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 2'b00, 1, 0);
    cmp("lit_flush_wrap", int'(flush_cnt), 0);
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
